// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single-port, synchronous-read main memory of the 8-bit pipelined
// processor between instruction fetch (IF) and the memory stage (EX). At most
// one access issues per cycle. The losing requester is stalled. Read data (or
// a write ack for EX) returns exactly one cycle after issue, tagged to the
// requester that issued it. A starvation counter forces an IF grant after
// MAX_STARVE consecutive EX grants while IF is waiting.
//
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   if_req, if_addr         fetch read request (held until granted) and PC
//   if_stall                IF requesting but not granted this cycle
//   if_valid, if_rdata      one-cycle completion of the last IF grant
//   ex_req, ex_we           data access request (held until granted), 1 = write
//   ex_addr, ex_wdata       data address and store data
//   ex_stall                EX requesting but not granted this cycle
//   ex_valid, ex_rdata      one-cycle completion (load data or write ack)
//   mem_en, mem_we          memory enable / write enable
//   mem_addr, mem_wdata     memory address / write data
//   mem_rdata               memory read data, valid the cycle after mem_en
//
// Requesters must hold address, data and we stable while stalled; nothing on
// the request side is latched here.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    StReset,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnEx   = 2'd2
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(MAX_STARVE);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;

  logic        force_if;
  logic        grant_if;
  logic        grant_ex;

  // State registers. Reset clears owner_q at once, so a completion that was
  // in flight when reset hit can never produce a valid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StReset;
      owner_q  <= OwnNone;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign force_if = if_req && (starve_q == StarveMax);

  // Arbitration, memory drive, stalls and next state.
  always_comb begin
    state_d   = state_q;
    owner_d   = OwnNone;
    starve_d  = starve_q;
    grant_if  = 1'b0;
    grant_ex  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_stall  = 1'b1;
    ex_stall  = 1'b1;

    unique case (state_q)
      StReset: begin
        // One dead cycle after reset: no grants, both sides stalled.
        state_d  = StRun;
        starve_d = 4'd0;
      end

      StRun: begin
        // EX normally wins; IF wins when it has waited MAX_STARVE EX grants.
        if (ex_req && !force_if) begin
          grant_ex = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end

        if (grant_ex) begin
          mem_en    = 1'b1;
          mem_we    = ex_we;
          mem_addr  = ex_addr;
          mem_wdata = ex_wdata;
          owner_d   = OwnEx;
        end else if (grant_if) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
          owner_d  = OwnIf;
        end

        if_stall = if_req && !grant_if;
        ex_stall = ex_req && !grant_ex;

        if (if_req && grant_ex) begin
          if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_if || !if_req) begin
          starve_d = 4'd0;
        end
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

  // Completion is purely a function of who owned last cycle's access.
  assign if_valid = (owner_q == OwnIf);
  assign ex_valid = (owner_q == OwnEx);
  assign if_rdata = mem_rdata;
  assign ex_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clock;
  logic       reset;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_stall;
  logic       if_valid;
  logic [7:0] if_rdata;
  logic       ex_req;
  logic       ex_we;
  logic [7:0] ex_addr;
  logic [7:0] ex_wdata;
  logic       ex_stall;
  logic       ex_valid;
  logic [7:0] ex_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  mem_port_arbiter #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MAX_STARVE(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_stall (if_stall),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .ex_req   (ex_req),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_stall (ex_stall),
    .ex_valid (ex_valid),
    .ex_rdata (ex_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port memory; contents start as addr ^ 0x5A.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem_rdata = 8'h00;
  end

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lands 1 time unit after the rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [9:0] pat_if;
    logic [9:0] pat_v;
    // Grant pattern with MAX_STARVE=3: E,E,E,I,E,E,E,I,E,E (bit i = IF grant).
    pat_if = 10'b00_1000_1000;
    // if_valid expected at cycle i (cycle 0 follows an IF grant).
    pat_v  = 10'b01_0001_0001;

    reset    = 1'b1;
    if_req   = 1'b1;
    if_addr  = 8'h00;
    ex_req   = 1'b0;
    ex_we    = 1'b0;
    ex_addr  = 8'h00;
    ex_wdata = 8'h00;

    // Reset asserted.
    tick();
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_stall", if_stall, 1);
    chk("rst_ex_stall", ex_stall, 1);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_ex_valid", ex_valid, 0);

    // Release reset: this cycle is RESET_S.
    tick();
    reset = 1'b0;
    #1;
    chk("rsts_mem_en", mem_en, 0);
    chk("rsts_if_stall", if_stall, 1);
    chk("rsts_ex_stall", ex_stall, 1);

    // First RUN cycle: IF granted at 0x00.
    tick();
    #1;
    chk("if1_mem_en", mem_en, 1);
    chk("if1_mem_addr", mem_addr, 8'h00);
    chk("if1_mem_we", mem_we, 0);
    chk("if1_if_stall", if_stall, 0);
    chk("if1_if_valid", if_valid, 0);

    // Completion of IF read, plus simultaneous IF/EX requests.
    tick();
    if_addr = 8'h10;
    ex_req  = 1'b1;
    ex_we   = 1'b0;
    ex_addr = 8'h80;
    #1;
    chk("if1_valid", if_valid, 1);
    chk("if1_rdata", if_rdata, 8'h5A);
    chk("sim_mem_addr", mem_addr, 8'h80);
    chk("sim_if_stall", if_stall, 1);
    chk("sim_ex_stall", ex_stall, 0);

    // EX read completes; EX drops, IF gets granted.
    tick();
    ex_req = 1'b0;
    #1;
    chk("exr_valid", ex_valid, 1);
    chk("exr_rdata", ex_rdata, 8'hDA);
    chk("exr_if_valid", if_valid, 0);
    chk("if2_mem_addr", mem_addr, 8'h10);
    chk("if2_if_stall", if_stall, 0);

    // IF completes; starvation run with both requesting for 10 cycles.
    tick();
    ex_req = 1'b1;
    #1;
    chk("if2_rdata", if_rdata, 8'h4A);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        tick();
        #1;
      end
      chk($sformatf("starve%0d_addr", i), mem_addr, pat_if[i] ? 8'h10 : 8'h80);
      chk($sformatf("starve%0d_if_valid", i), if_valid, pat_v[i]);
      chk($sformatf("starve%0d_if_stall", i), if_stall, !pat_if[i]);
    end

    // EX write 0xA5 to 0x40.
    tick();
    if_req   = 1'b0;
    ex_we    = 1'b1;
    ex_addr  = 8'h40;
    ex_wdata = 8'hA5;
    #1;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h40);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    chk("wr_prev_valid", ex_valid, 1);

    // Read back 0x40; write ack this cycle.
    tick();
    ex_we    = 1'b0;
    ex_wdata = 8'h00;
    #1;
    chk("wr_ack", ex_valid, 1);
    chk("rd40_mem_we", mem_we, 0);
    chk("rd40_mem_addr", mem_addr, 8'h40);

    tick();
    ex_req = 1'b0;
    #1;
    chk("rd40_valid", ex_valid, 1);
    chk("rd40_rdata", ex_rdata, 8'hA5);
    chk("idle_mem_en", mem_en, 0);

    // EX read at 0x80, then reset in the following cycle.
    tick();
    ex_req  = 1'b1;
    ex_addr = 8'h80;
    #1;
    chk("pre_rst_ex_valid", ex_valid, 0);
    chk("pre_rst_mem_en", mem_en, 1);

    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_ex_stall", ex_stall, 1);
    chk("mid_rst_if_stall", if_stall, 1);
    ex_req = 1'b0;

    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ex_valid", ex_valid, 0);
    chk("post_rst_if_stall", if_stall, 1);
    chk("post_rst_ex_stall", ex_stall, 1);

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk($sformatf("idle%0d_mem_en", i), mem_en, 0);
      chk($sformatf("idle%0d_if_stall", i), if_stall, 0);
      chk($sformatf("idle%0d_ex_stall", i), ex_stall, 0);
      chk($sformatf("idle%0d_if_valid", i), if_valid, 0);
      chk($sformatf("idle%0d_ex_valid", i), ex_valid, 0);
    end

    // Counter stayed at 0: both request again, IF forced on the fourth cycle.
    tick();
    if_req  = 1'b1;
    if_addr = 8'h10;
    ex_req  = 1'b1;
    ex_addr = 8'h80;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      chk($sformatf("restart%0d_addr", i), mem_addr, (i == 3) ? 8'h10 : 8'h80);
    end

    tick();
    if_req = 1'b0;
    ex_req = 1'b0;
    #1;
    chk("restart_if_valid", if_valid, 1);
    chk("restart_if_rdata", if_rdata, 8'h4A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
